// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared types and constants for the median output packer
//
// Purpose: pixel/word widths, the frame FSM state encoding and the FIFO
// entry type used by median_out_packer and pix_word_fifo.
// Ports: none (package).

package median_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PACK       = 4;
  localparam int WORD_WIDTH = PACK * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A packed word plus its end-of-frame marker travel together through the FIFO.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic                  last;
  } word_t;

endpackage

// File: rtl/median_out_packer_if.sv
// rtl/median_out_packer_if.sv - pixel-in / word-out bus of the median output packer
//
// Purpose: bundles the filter-side pixel stream and the writer-side word
// handshake.
// Signals: en, valid_in, data_in (pixel side); out_data, out_valid,
// out_ready, out_last (word side).
// Modports: master = packer (drives the word stream), slave = the
// surrounding logic (drives pixels and out_ready).

interface median_out_packer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    en;
  logic                    valid_in;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [4*DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport master (
    input  en, valid_in, data_in, out_ready,
    output out_data, out_valid, out_last
  );

  modport slave (
    output en, valid_in, data_in, out_ready,
    input  out_data, out_valid, out_last
  );
endinterface

// File: rtl/pix_word_fifo.sv
// rtl/pix_word_fifo.sv - first-word-fall-through FIFO of packed pixel words
//
// Purpose: buffers word_t entries between the packer and the frame writer.
// The head entry is read straight from the storage registers, so a word
// written on an edge is visible at the output right after that edge.
// Ports: clk, reset (async active-low), push/push_word, pop, head,
// full, empty.

module pix_word_fifo
  import median_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  word_t push_word,
  input  logic  pop,
  output word_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  word_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // When full, a same-cycle pop frees the slot the write lands in
  // (wr_ptr == rd_ptr), so the push may proceed.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/median_out_packer.sv
// rtl/median_out_packer.sv - packs 4 filter pixels per word and streams frame words out
//
// Purpose: collects accepted pixels into 32-bit words (first pixel in the
// low byte), zero-pads and flags the final word of each frame, buffers
// words in pix_word_fifo and pulses frame_done after the final word is
// taken downstream.
// Ports: clk, reset (async active-low), bus (median_out_packer_if.master:
// pixel input and word handshake), frame_done (1-cycle pulse), overflow
// (sticky word-drop flag).

module median_out_packer
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  median_out_packer_if.master bus,
  output logic                frame_done,
  output logic                overflow
);

  localparam int P        = IMG_W * IMG_H;
  localparam int PIX_BITS = (P > 1) ? $clog2(P) : 1;

  state_t                state_q;
  state_t                state_d;
  logic [1:0]            lane_cnt;
  logic [PIX_BITS-1:0]   pix_cnt;
  logic [DATA_WIDTH-1:0] lane_q [PACK];
  logic                  overflow_q;

  word_t push_word;
  word_t head;
  logic  full;
  logic  empty;
  logic  accept;
  logic  last_pix;
  logic  push;
  logic  pop;
  logic  drop;

  // Pixels are ignored only while waiting for the final word to leave;
  // the DONE cycle already accepts the next frame.
  assign accept   = bus.valid_in && bus.en && (state_q != DRAIN);
  assign last_pix = (pix_cnt == PIX_BITS'(P - 1));
  assign push     = accept && ((lane_cnt == 2'(PACK - 1)) || last_pix);
  assign pop      = !empty && bus.out_ready;
  assign drop     = push && full && !pop;

  // Lanes below lane_cnt were filled earlier in this word, the current
  // pixel goes into lane_cnt, and lanes above stay zero (final-word pad).
  always_comb begin
    push_word      = '0;
    push_word.last = last_pix;
    for (int i = 0; i < PACK; i++) begin
      if (i < int'(lane_cnt)) begin
        push_word.data[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
      end else if (i == int'(lane_cnt)) begin
        push_word.data[i*DATA_WIDTH +: DATA_WIDTH] = bus.data_in;
      end
    end
  end

  pix_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_cnt   <= '0;
      pix_cnt    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < PACK; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        lane_q[lane_cnt] <= bus.data_in;
        lane_cnt         <= push ? 2'd0 : lane_cnt + 2'd1;
        pix_cnt          <= last_pix ? '0 : pix_cnt + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // If the final word itself is dropped there is nothing left to wait for,
  // so the frame closes immediately instead of stalling in DRAIN.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = last_pix ? (drop ? DONE : DRAIN) : RUN;
        end
      end
      RUN: begin
        if (accept && last_pix) begin
          state_d = drop ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        if (accept) begin
          state_d = last_pix ? (drop ? DONE : DRAIN) : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = head.data;
  assign bus.out_last  = head.last && !empty;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_median_out_packer.sv
// tb/tb_median_out_packer.sv - scoreboard bench for median_out_packer

module tb_median_out_packer;

  localparam int BW    = 256;
  localparam int BH    = 256;
  localparam int BP    = BW * BH;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic b_reset;
  logic s_reset;
  logic b_frame_done;
  logic b_overflow;
  logic s_frame_done;
  logic s_overflow;

  median_out_packer_if #(.DATA_WIDTH(8)) b_if ();
  median_out_packer_if #(.DATA_WIDTH(8)) s_if ();

  median_out_packer #(
    .DATA_WIDTH (8),
    .IMG_W      (BW),
    .IMG_H      (BH),
    .FIFO_DEPTH (DEPTH)
  ) u_big (
    .clk        (clk),
    .reset      (b_reset),
    .bus        (b_if),
    .frame_done (b_frame_done),
    .overflow   (b_overflow)
  );

  median_out_packer #(
    .DATA_WIDTH (8),
    .IMG_W      (3),
    .IMG_H      (3),
    .FIFO_DEPTH (DEPTH)
  ) u_small (
    .clk        (clk),
    .reset      (s_reset),
    .bus        (s_if),
    .frame_done (s_frame_done),
    .overflow   (s_overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Big-instance reference model: {last, data} entries mirror FIFO occupancy.
  logic [32:0] b_q[$];
  int          b_pix;
  int          b_lane;
  logic [31:0] b_acc;
  bit          b_drain;
  bit          b_fd_pend;
  bit          b_ovf;
  int          b_words;
  int          b_fd_cnt;
  logic [31:0] b_first;
  logic [31:0] b_lastw;
  logic [31:0] b_recent;

  task automatic b_model_reset();
    b_q.delete();
    b_pix     = 0;
    b_lane    = 0;
    b_acc     = '0;
    b_drain   = 0;
    b_fd_pend = 0;
    b_ovf     = 0;
    b_words   = 0;
    b_fd_cnt  = 0;
    b_first   = '0;
    b_lastw   = '0;
    b_recent  = '0;
  endtask

  task automatic b_cycle(input bit v, input bit e, input logic [7:0] d, input bit rdy);
    logic [32:0] ex;
    bit          pop;
    bit          acc;
    b_if.valid_in  = v;
    b_if.en        = e;
    b_if.data_in   = d;
    b_if.out_ready = rdy;
    @(negedge clk);
    check("out_valid", b_if.out_valid, 64'(b_q.size() != 0));
    check("frame_done", b_frame_done, b_fd_pend);
    if (b_frame_done) b_fd_cnt++;
    b_fd_pend = 0;
    check("overflow", b_overflow, b_ovf);
    pop = b_if.out_valid && rdy;
    ex  = '0;
    if (pop && b_q.size() != 0) begin
      ex = b_q.pop_front();
      check("out_data", b_if.out_data, ex[31:0]);
      check("out_last", b_if.out_last, ex[32]);
      if (b_words == 0) b_first = b_if.out_data;
      if (ex[32]) b_lastw = b_if.out_data;
      b_recent = b_if.out_data;
      b_words++;
    end
    acc = v && e && !b_drain;
    if (acc) begin
      b_acc[8*b_lane +: 8] = d;
      if (b_lane == 3 || b_pix == BP - 1) begin
        if (b_q.size() < DEPTH) b_q.push_back({b_pix == BP - 1, b_acc});
        else b_ovf = 1;
        b_acc  = '0;
        b_lane = 0;
      end else begin
        b_lane++;
      end
      if (b_pix == BP - 1) begin
        b_pix   = 0;
        b_drain = 1;
      end else begin
        b_pix++;
      end
    end
    if (pop && ex[32]) begin
      b_drain   = 0;
      b_fd_pend = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic b_hard_reset();
    b_if.valid_in  = 1'b0;
    b_if.en        = 1'b0;
    b_if.out_ready = 1'b0;
    b_reset        = 1'b0;
    b_model_reset();
    @(posedge clk);
    #1;
    b_reset = 1'b1;
  endtask

  // Small (3x3) instance: expected words queued up front, popped on handshake.
  logic [32:0] s_q[$];
  int          s_words = 0;
  int          s_fd    = 0;
  bit          s_done  = 0;

  always @(negedge clk) begin
    if (s_reset && s_if.out_valid && s_if.out_ready) begin
      if (s_q.size() != 0) begin
        logic [32:0] sx;
        sx = s_q.pop_front();
        check("s_data", s_if.out_data, sx[31:0]);
        check("s_last", s_if.out_last, sx[32]);
      end else begin
        check("s_extra_word", 1, 0);
      end
      s_words++;
    end
    if (s_reset && s_frame_done) s_fd++;
  end

  initial begin
    s_if.valid_in  = 1'b0;
    s_if.en        = 1'b0;
    s_if.data_in   = '0;
    s_if.out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    s_q.push_back(33'h0_13121110);
    s_q.push_back(33'h0_17161514);
    s_q.push_back(33'h1_00000018);
    for (int k = 0; k < 9; k++) begin
      s_if.valid_in  = 1'b1;
      s_if.en        = 1'b1;
      s_if.data_in   = 8'(8'h10 + k);
      s_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    s_if.valid_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("s_word_count", s_words, 3);
    check("s_frame_done_count", s_fd, 1);
    check("s_leftover", s_q.size(), 0);
    check("s_overflow", s_overflow, 0);
    s_done = 1;
  end

  initial begin
    b_if.valid_in  = 1'b0;
    b_if.en        = 1'b0;
    b_if.data_in   = '0;
    b_if.out_ready = 1'b0;
    b_reset        = 1'b0;
    s_reset        = 1'b0;
    b_model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", b_if.out_valid, 0);
    check("rst_out_last", b_if.out_last, 0);
    check("rst_out_data", b_if.out_data, 0);
    check("rst_frame_done", b_frame_done, 0);
    check("rst_overflow", b_overflow, 0);
    b_reset = 1'b1;
    s_reset = 1'b1;

    // Backpressure: 40 pixels with out_ready low, word 8 is lost.
    for (int i = 0; i < 40; i++) begin
      b_cycle(1, 1, i[7:0], 0);
      if (i == 31) begin
        check("ovf_after_31", b_overflow, 0);
        check("valid_when_full", b_if.out_valid, 1);
      end
      if (i == 35) check("ovf_after_35", b_overflow, 1);
    end
    repeat (10) b_cycle(0, 0, 8'h00, 1);
    check("ovf_words_0_7", b_words, 8);

    // Asynchronous reset mid-frame after 6 pixels.
    for (int i = 0; i < 6; i++) b_cycle(1, 1, 8'(8'h60 + i), 0);
    #2;
    b_reset = 1'b0;
    #1;
    check("async_rst_valid", b_if.out_valid, 0);
    check("async_rst_ovf", b_overflow, 0);
    b_model_reset();
    b_if.valid_in = 1'b0;
    @(posedge clk);
    #1;
    b_reset = 1'b1;
    repeat (3) b_cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) b_cycle(1, 1, 8'(8'hA0 + i), 1);
    repeat (3) b_cycle(0, 0, 8'h00, 1);
    check("post_rst_word", b_recent, 32'hA3A2A1A0);
    check("post_rst_fdone", b_fd_cnt, 0);

    // FIFO full, pop on the same edge the completing pixel lands.
    b_hard_reset();
    for (int i = 0; i < 35; i++) b_cycle(1, 1, i[7:0], 0);
    b_cycle(1, 1, 8'd35, 1);
    repeat (10) b_cycle(0, 0, 8'h00, 1);
    check("same_edge_ovf", b_overflow, 0);
    check("same_edge_words", b_words, 9);

    // en gating: en=0 pixels never reach the output.
    b_hard_reset();
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) b_cycle(1, 1, 8'(8'h40 + k), 1);
      else            b_cycle(1, 0, 8'hEE, 1);
    end
    repeat (4) b_cycle(0, 0, 8'h00, 1);
    check("en_words", b_words, 2);

    // Full 256x256 frame at full rate.
    b_hard_reset();
    for (int i = 0; i < BP; i++) b_cycle(1, 1, i[7:0], 1);
    repeat (6) b_cycle(0, 0, 8'h00, 1);
    check("frame_word0", b_first, 32'h03020100);
    check("frame_lastword", b_lastw, 32'hFFFEFDFC);
    check("frame_words", b_words, BP / 4);
    check("frame_done_pulses", b_fd_cnt, 1);
    check("frame_overflow", b_overflow, 0);

    for (int t = 0; t < 200 && !s_done; t++) @(posedge clk);
    if (!s_done) check("small_timeout", 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/median_out_packer.md
# median_out_packer

Output-side collector for the median-filter datapath. It consumes the filter's 8-bit pixel stream (data plus valid strobe) and packs four consecutive pixels into one 32-bit word. Words are buffered in a small FIFO and presented on a ready/valid interface toward the frame writer. It counts pixels against the configured frame size, pads and flags the final word, and pulses `frame_done` once every word of the frame has been delivered.

## Interface
- `DATA_WIDTH`, 8, pixel width; word width is 4*DATA_WIDTH.
- `IMG_W`, 256, pixels per row.
- `IMG_H`, 256, rows per frame.
- `FIFO_DEPTH`, 8, word FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `en`  in  1  input enable; pixels are accepted only when `en`=1.
- `data_in`  in  DATA_WIDTH  pixel from the filter datapath.
- `valid_in`  in  1  pixel strobe from the filter; no backpressure toward the filter.
- `out_data`  out  4*DATA_WIDTH  packed word; first pixel occupies bits [7:0].
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  downstream accepts the word when `out_valid`=1 and `out_ready`=1.
- `out_last`  out  1  head word is the frame's final word; valid only when `out_valid`=1.
- `frame_done`  out  1  one-cycle pulse after the last word handshake.
- `overflow`  out  1  sticky; set when a completed word is dropped.

## Operation
- Pixel accept: `valid_in`=1 and `en`=1 at a rising edge. `valid_in` with `en`=0 is ignored and not counted.
- Lane counter 0..3. An accepted pixel is written to lane[lane_cnt]. The pixel counter runs from 0 to P-1, where P = IMG_W*IMG_H.
- A word completes on the 4th lane, or on pixel P-1 (the last pixel of the frame).
  - Unfilled lanes of the final word are zero.
  - `last` is stored alongside the word in the FIFO.
- FSM states:
  - IDLE: no pixels counted → RUN on the first accepted pixel.
  - RUN → DRAIN when pixel P-1 is accepted.
  - DRAIN: input ignored; waits for the handshake of the last word → DONE.
  - DONE: asserts `frame_done` for one cycle → IDLE, with counters at zero.
- Push when FIFO full:
  - Without a same-cycle pop, the word is dropped and `overflow` is set. The counters still advance.
  - With a same-cycle pop, the push succeeds.
- The output side is independent of `en`; draining continues while `en`=0.
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `frame_done`=0, `overflow`=0, FIFO empty, counters 0, FSM in IDLE.
- Reset mid-frame: the partial word and FIFO contents are discarded; no `frame_done` is produced.
- `overflow` is cleared only by reset.

## Timing
- Pixel-to-word latency: a word completed at edge k is visible with `out_valid`=1 after edge k. The FIFO is first-word-fall-through with a registered head.
- Throughput: one pixel per cycle in; one word per cycle out. Sustained input needs only `out_ready` ≥ 25% duty.
- Handshake rules:
  - `out_data`/`out_last` hold stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a handshake, except on reset.
- `frame_done` rises in the cycle after the edge on which the last word is handshaken.
- The next frame's pixels are accepted from the DONE cycle onward. Pixels arriving during DRAIN are dropped; the datapath guarantees an inter-frame gap.
- FIFO capacity: 8 words = 32 pixels of slack with `out_ready`=0.

## Structure
- Package `median_pkg`:
  - `DATA_WIDTH` and `PACK`=4 constants.
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - `word_t` struct {data[4*DATA_WIDTH], last}.
- Sub-module `pix_word_fifo`: a synchronous FWFT FIFO of `word_t`, parameterised by depth, with full/empty flags and simultaneous push/pop.
- Top level holds the lane register, the counters, the FSM and overflow detection.

## Test plan
- Full frame (256x256), `out_ready`=1, pixel i = i mod 256 → 16384 words:
  - word0 = 0x03020100.
  - word16383 = 0xFFFEFDFC with `out_last`=1.
  - Exactly one `frame_done` pulse; `overflow`=0.
- `out_ready`=0 while 40 pixels stream in:
  - FIFO is full after pixel 31.
  - Word 8 (pixels 32-35) is dropped and `overflow`=1 after pixel 35.
  - Raising `out_ready` yields words 0-7 intact.
- FIFO full, `out_ready`=1 on the same edge a 4th pixel lands → push succeeds, no overflow, word order preserved.
- IMG_W=3, IMG_H=3, pixels 0x10..0x18:
  - Output is 3 words: 0x13121110, 0x17161514, 0x00000018.
  - The last word has `out_last`=1.
- Pixels interleaved with `en`=0/`valid_in`=1 cycles → ignored pixels are absent from the output and the word count is unchanged.
- Reset pulled low after 6 pixels:
  - `out_valid`=0 and `overflow`=0 immediately (async).
  - No `frame_done`.
  - The next 4 pixels 0xA0..0xA3 give word 0xA3A2A1A0.
